// File: rtl/pll_lock_supervisor.sv
// PLL reset sequencer and lock qualifier running in the clk_74a reference domain.
// Define PLL_LOCK_SUPERVISOR_LOSS_COUNT_EN to add the saturating loss_count port.
module pll_lock_supervisor #(
  parameter int unsigned RST_PULSE_CYCLES    = 32,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 74250,
  parameter int unsigned STABLE_CYCLES       = 4096,
  parameter int unsigned MAX_RETRIES         = 7
) (
  input  logic       clk_74a,
  input  logic       reset_n,
  input  logic       pll_locked,
  input  logic       retry_req,
  output logic       pll_rst,
  output logic       core_reset_n,
  output logic [2:0] state,
  output logic [3:0] retry_count,
  output logic       fail
`ifdef PLL_LOCK_SUPERVISOR_LOSS_COUNT_EN
  ,
  output logic [7:0] loss_count
`endif
);

  localparam int unsigned CNT_MAX_A = (RST_PULSE_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                                      RST_PULSE_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int unsigned CNT_MAX   = (CNT_MAX_A > STABLE_CYCLES) ? CNT_MAX_A : STABLE_CYCLES;
  localparam int unsigned CNT_W     = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned RC_W      = 4;

  localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [RC_W-1:0]  RETRY_MAX    = RC_W'(MAX_RETRIES);

  typedef enum logic [2:0] {
    PULSE     = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RC_W-1:0]  rc_d;
  logic             lk_meta, lk;
  logic             attempt_bad;

  assign state = state_q;

  // Next-state logic; the shared elapsed-cycle counter restarts on every state change.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rc_d        = retry_count;
    attempt_bad = 1'b0;
    unique case (state_q)
      PULSE: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == PULSE_LAST) state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (lk) state_d = STABLE;
        else if (cnt_q == TIMEOUT_LAST) attempt_bad = 1'b1;
      end
      STABLE: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (!lk) begin
          attempt_bad = 1'b1;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = RUN;
          rc_d    = '0;
        end
      end
      RUN: begin
        if (!lk) begin
          state_d = PULSE;
          rc_d    = '0;
        end
      end
      FAIL: begin
        if (retry_req) begin
          state_d = PULSE;
          rc_d    = '0;
        end
      end
      default: state_d = PULSE;
    endcase
    // Timeouts and stability glitches share one retry budget.
    if (attempt_bad) begin
      if (retry_count < RETRY_MAX) begin
        rc_d    = retry_count + RC_W'(1);
        state_d = PULSE;
      end else begin
        state_d = FAIL;
      end
    end
    if (state_d != state_q) cnt_d = '0;
  end

  // State, counters, lock synchronizer and outputs registered from the next state.
  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) begin
      lk_meta      <= 1'b0;
      lk           <= 1'b0;
      state_q      <= PULSE;
      cnt_q        <= '0;
      retry_count  <= '0;
      pll_rst      <= 1'b1;
      core_reset_n <= 1'b0;
      fail         <= 1'b0;
    end else begin
      lk_meta      <= pll_locked;
      lk           <= lk_meta;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      retry_count  <= rc_d;
      pll_rst      <= (state_d == PULSE) || (state_d == FAIL);
      core_reset_n <= (state_d == RUN);
      fail         <= (state_d == FAIL);
    end
  end

`ifdef PLL_LOCK_SUPERVISOR_LOSS_COUNT_EN
  // Saturating count of lock losses seen while running.
  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) begin
      loss_count <= 8'd0;
    end else if ((state_q == RUN) && (state_d == PULSE) && (loss_count != 8'hFF)) begin
      loss_count <= loss_count + 8'd1;
    end
  end
`endif

endmodule
